// File: rtl/pattern_filter_multi.sv
// pattern_filter_multi: store-and-forward filter matching payload words against NUM_PATTERNS masked patterns.
// Define PATTERN_FILTER_STATS_EN to build the match/drop/oversize counters; otherwise they read 0.
module pattern_filter_multi #(
  parameter int DATA_WIDTH    = 64,
  parameter int CTRL_WIDTH    = DATA_WIDTH/8,
  parameter int NUM_PATTERNS  = 4,
  parameter int HDR_WORDS     = 3,
  parameter int BUF_ADDR_BITS = 8
)(
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DATA_WIDTH-1:0]          in_data,
  input  logic [CTRL_WIDTH-1:0]          in_ctrl,
  input  logic                           in_wr,
  output logic                           in_rdy,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [CTRL_WIDTH-1:0]          out_ctrl,
  output logic                           out_wr,
  input  logic                           out_rdy,
  input  logic [NUM_PATTERNS*DATA_WIDTH-1:0] cfg_patterns,
  input  logic [NUM_PATTERNS*CTRL_WIDTH-1:0] cfg_masks,
  input  logic [NUM_PATTERNS-1:0]        cfg_pattern_en,
  input  logic                           cfg_drop_mode,
  input  logic                           cfg_clear,
  output logic [NUM_PATTERNS*32-1:0]     match_count,
  output logic [31:0]                    drop_count,
  output logic [31:0]                    oversize_count
);
  localparam int AW = BUF_ADDR_BITS;
  localparam int W  = DATA_WIDTH + CTRL_WIDTH;
  typedef enum logic [2:0] {IDLE, MODHDR, HDR, PAYLOAD, DISCARD} state_t;
  state_t r_state, w_nxt;
  logic [W-1:0] r_mem [2**AW];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr, r_commit_ptr, r_pkt_start, w_len, w_free;
  logic [7:0] r_hdr_cnt;
  logic [NUM_PATTERNS-1:0] r_flags, w_hit, w_hits;
  logic r_body, r_in_rdy, r_out_wr;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [CTRL_WIDTH-1:0] r_out_ctrl;
  logic w_ctl, w_store, w_start, w_end, w_cmp, w_ovf, w_any, w_drop;

  assign w_ctl    = |in_ctrl;
  assign w_len    = r_wr_ptr + 1'b1 - r_pkt_start;
  assign w_free   = r_rd_ptr - r_wr_ptr - 1'b1;
  assign w_hits   = w_cmp ? w_hit : '0;
  assign w_any    = |(r_flags | w_hits);
  assign w_drop   = cfg_drop_mode && w_any;
  assign in_rdy   = r_in_rdy;
  assign out_wr   = r_out_wr;
  assign out_data = r_out_data;
  assign out_ctrl = r_out_ctrl;

  for (genvar g = 0; g < NUM_PATTERNS; g++) begin : g_pat
    logic [DATA_WIDTH-1:0] w_bm;
    for (genvar b = 0; b < CTRL_WIDTH; b++) begin : g_byte
      assign w_bm[b*8 +: 8] = {8{cfg_masks[g*CTRL_WIDTH+b]}};
    end
    assign w_hit[g] = cfg_pattern_en[g] &&
                      (((in_data ^ cfg_patterns[g*DATA_WIDTH +: DATA_WIDTH]) & w_bm) == '0);
  end

  always_ff @(posedge clk)
    if (reset) r_state <= IDLE;
    else r_state <= w_nxt;

  always_comb begin
    w_nxt   = r_state;
    w_store = 1'b0;
    w_start = 1'b0;
    w_end   = 1'b0;
    w_cmp   = 1'b0;
    w_ovf   = 1'b0;
    case (r_state)
      IDLE: if (in_wr && w_ctl) begin
        w_store = 1'b1;
        w_start = 1'b1;
        w_nxt   = MODHDR;
      end
      MODHDR: if (in_wr) begin
        w_store = 1'b1;
        w_nxt   = w_ctl ? MODHDR : ((HDR_WORDS == 1) ? PAYLOAD : HDR);
      end
      HDR: if (in_wr) begin
        w_store = 1'b1;
        w_end   = w_ctl;
        w_nxt   = w_ctl ? IDLE : (r_hdr_cnt + 8'd1 == 8'(HDR_WORDS)) ? PAYLOAD : HDR;
      end
      PAYLOAD: if (in_wr) begin
        w_store = 1'b1;
        w_cmp   = 1'b1;
        w_end   = w_ctl;
        w_nxt   = w_ctl ? IDLE : PAYLOAD;
      end
      DISCARD: w_nxt = (in_wr && w_ctl && r_body) ? IDLE : DISCARD;
      default: w_nxt = IDLE;
    endcase
    // Leave two words of slack so a full buffer never aliases empty.
    if (w_store && !w_end && r_state != IDLE && w_len == AW'(2**AW - 2)) begin
      w_ovf = 1'b1;
      w_nxt = DISCARD;
    end
  end

  always_ff @(posedge clk)
    if (w_store) r_mem[r_wr_ptr] <= {in_ctrl, in_data};

  always_ff @(posedge clk)
    if (reset) begin
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_pkt_start  <= '0;
      r_hdr_cnt    <= '0;
      r_flags      <= '0;
      r_body       <= 1'b0;
      r_in_rdy     <= 1'b0;
    end else begin
      r_wr_ptr  <= (w_ovf || (w_end && w_drop)) ? r_pkt_start : w_store ? r_wr_ptr + 1'b1 : r_wr_ptr;
      if (w_end && !w_drop) r_commit_ptr <= r_wr_ptr + 1'b1;
      if (w_start) r_pkt_start <= r_wr_ptr;
      r_flags   <= w_start ? '0 : (r_flags | w_hits);
      r_body    <= w_start ? 1'b0 : (r_body | (in_wr && !w_ctl && r_state != IDLE));
      r_hdr_cnt <= (r_state == MODHDR) ? 8'd1 :
                   (r_state == HDR && in_wr && !w_ctl) ? r_hdr_cnt + 8'd1 : r_hdr_cnt;
      r_in_rdy  <= w_free >= AW'(3);
    end

  always_ff @(posedge clk)
    if (reset) begin
      r_rd_ptr   <= '0;
      r_out_wr   <= 1'b0;
      r_out_data <= '0;
      r_out_ctrl <= '0;
    end else if (r_rd_ptr != r_commit_ptr && out_rdy) begin
      {r_out_ctrl, r_out_data} <= r_mem[r_rd_ptr];
      r_out_wr <= 1'b1;
      r_rd_ptr <= r_rd_ptr + 1'b1;
    end else begin
      r_out_wr <= 1'b0;
    end

`ifdef PATTERN_FILTER_STATS_EN
  logic [NUM_PATTERNS*32-1:0] r_match;
  logic [31:0] r_drop, r_oversize;
  always_ff @(posedge clk)
    if (reset || cfg_clear) begin
      r_match    <= '0;
      r_drop     <= '0;
      r_oversize <= '0;
    end else begin
      if (w_end && w_drop) r_drop <= r_drop + 32'd1;
      if (w_ovf) r_oversize <= r_oversize + 32'd1;
      for (int i = 0; i < NUM_PATTERNS; i++)
        if (w_end && (r_flags[i] | w_hits[i])) r_match[i*32 +: 32] <= r_match[i*32 +: 32] + 32'd1;
    end
  assign match_count    = r_match;
  assign drop_count     = r_drop;
  assign oversize_count = r_oversize;
`else
  logic w_unused;
  assign w_unused       = cfg_clear;
  assign match_count    = '0;
  assign drop_count     = '0;
  assign oversize_count = '0;
`endif
endmodule

// File: tb/tb_pattern_filter_multi.sv
// tb_pattern_filter_multi: directed checks of framing, masked matching, drop/forward, oversize and backpressure.
// Counter expectations scale by S, which is 0 when PATTERN_FILTER_STATS_EN is not defined.
module tb_pattern_filter_multi;
  localparam int DW = 64, CW = 8, NP = 4, AW = 4;
`ifdef PATTERN_FILTER_STATS_EN
  localparam int S = 1;
`else
  localparam int S = 0;
`endif
  localparam logic [63:0] PAT = 64'h00AABBCCDDEEFF11;

  logic clk = 1'b0, reset = 1'b1;
  logic [DW-1:0] in_data = '0, out_data;
  logic [CW-1:0] in_ctrl = '0, out_ctrl;
  logic in_wr = 1'b0, in_rdy, out_wr, out_rdy = 1'b1;
  logic [NP*DW-1:0] cfg_patterns = '0;
  logic [NP*CW-1:0] cfg_masks = '0;
  logic [NP-1:0] cfg_pattern_en = '0;
  logic cfg_drop_mode = 1'b0, cfg_clear = 1'b0;
  logic [NP*32-1:0] match_count;
  logic [31:0] drop_count, oversize_count;

  int checks = 0, failures = 0, cyc = 0, last_cyc = 0, base = 0;
  logic [63:0] rx_d[$], ex_d[$];
  logic [7:0] rx_c[$], ex_c[$];
  int rx_t[$];

  pattern_filter_multi #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_PATTERNS(NP), .HDR_WORDS(3),
                         .BUF_ADDR_BITS(AW)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .cfg_patterns(cfg_patterns), .cfg_masks(cfg_masks), .cfg_pattern_en(cfg_pattern_en),
    .cfg_drop_mode(cfg_drop_mode), .cfg_clear(cfg_clear), .match_count(match_count),
    .drop_count(drop_count), .oversize_count(oversize_count));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (out_wr) begin
      rx_d.push_back(out_data);
      rx_c.push_back(out_ctrl);
      rx_t.push_back(cyc);
    end

  task automatic send_word(input logic [63:0] d, input logic [7:0] c);
    int n = 0;
    @(negedge clk);
    while (!in_rdy && n < 500) begin
      in_wr = 1'b0;
      n++;
      @(negedge clk);
    end
    if (n >= 500) begin
      failures++;
      $display("FAIL in_rdy_timeout: in_rdy=%0b after %0d cycles, required 1", in_rdy, n);
    end
    in_data = d;
    in_ctrl = c;
    in_wr = 1'b1;
    last_cyc = cyc;
  endtask

  task automatic idle();
    @(negedge clk);
    in_wr = 1'b0;
  endtask

  task automatic send_pkt(input int n, input logic [63:0] hit, input int hit_at, input int tag, input bit pass);
    for (int i = 0; i < n; i++) begin
      logic [63:0] d;
      logic [7:0] c;
      d = (i == hit_at) ? hit : {8'(tag), 8'(i), 48'h123456789ABC};
      c = (i == 0) ? 8'hFF : (i == n - 1) ? 8'h01 : 8'h00;
      send_word(d, c);
      if (pass) begin
        ex_d.push_back(d);
        ex_c.push_back(c);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_wr = 1'b0;
    cfg_clear = 1'b0;
    out_rdy = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ex_d.delete();
    ex_c.delete();
    base = rx_d.size();
  endtask

  task automatic set_pat0(input bit drop);
    cfg_patterns = {192'd0, PAT};
    cfg_masks = {24'd0, 8'h7F};
    cfg_pattern_en = 4'b0001;
    cfg_drop_mode = drop;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks += 6;
    if (in_rdy !== 1'b0) begin failures++; $display("FAIL reset_in_rdy: got %0b need 0", in_rdy); end
    if (out_wr !== 1'b0) begin failures++; $display("FAIL reset_out_wr: got %0b need 0", out_wr); end
    if (out_data !== 64'd0) begin failures++; $display("FAIL reset_out_data: got %h need 0", out_data); end
    if (drop_count !== 32'd0) begin failures++; $display("FAIL reset_drop: got %0d need 0", drop_count); end
    if (oversize_count !== 32'd0) begin failures++; $display("FAIL reset_oversize: got %0d need 0", oversize_count); end
    if (match_count !== '0) begin failures++; $display("FAIL reset_match: got %h need 0", match_count); end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_rdy !== 1'b1) begin failures++; $display("FAIL reset_release_in_rdy: got %0b need 1", in_rdy); end
  endtask

  task automatic test_drop();
    do_reset();
    set_pat0(1'b1);
    send_pkt(8, 64'h55AABBCCDDEEFF11, 5, 1, 1'b0);
    idle();
    repeat (20) @(negedge clk);
    checks += 3;
    if (rx_d.size() != base) begin failures++; $display("FAIL drop_no_output: got %0d words need 0", rx_d.size() - base); end
    if (drop_count !== 32'(S)) begin failures++; $display("FAIL drop_count: got %0d need %0d", drop_count, S); end
    if (match_count[31:0] !== 32'(S)) begin failures++; $display("FAIL drop_match0: got %0d need %0d", match_count[31:0], S); end
  endtask

  task automatic test_forward();
    do_reset();
    set_pat0(1'b0);
    send_pkt(8, 64'h55AABBCCDDEEFF11, 5, 2, 1'b1);
    idle();
    repeat (20) @(negedge clk);
    checks += 4;
    if (rx_d.size() != base + 8) begin failures++; $display("FAIL fwd_size: got %0d need 8", rx_d.size() - base); end
    for (int i = 0; i < ex_d.size() && base + i < rx_d.size(); i++) begin
      checks++;
      if (rx_d[base+i] !== ex_d[i] || rx_c[base+i] !== ex_c[i]) begin
        failures++;
        $display("FAIL fwd_word%0d: got %h/%h need %h/%h", i, rx_c[base+i], rx_d[base+i], ex_c[i], ex_d[i]);
      end
    end
    if (rx_d.size() > base && rx_t[base] != last_cyc + 2) begin
      failures++;
      $display("FAIL fwd_latency: first out cycle %0d need %0d", rx_t[base], last_cyc + 2);
    end
    if (match_count[31:0] !== 32'(S)) begin failures++; $display("FAIL fwd_match0: got %0d need %0d", match_count[31:0], S); end
    if (drop_count !== 32'd0) begin failures++; $display("FAIL fwd_drop: got %0d need 0", drop_count); end
  endtask

  task automatic test_hdr_only();
    do_reset();
    set_pat0(1'b1);
    send_pkt(8, PAT, 2, 3, 1'b1);
    idle();
    repeat (20) @(negedge clk);
    checks += 3;
    if (rx_d.size() != base + 8) begin failures++; $display("FAIL hdr_size: got %0d need 8", rx_d.size() - base); end
    for (int i = 0; i < ex_d.size() && base + i < rx_d.size(); i++) begin
      checks++;
      if (rx_d[base+i] !== ex_d[i]) begin failures++; $display("FAIL hdr_word%0d: got %h need %h", i, rx_d[base+i], ex_d[i]); end
    end
    if (match_count[31:0] !== 32'd0) begin failures++; $display("FAIL hdr_match0: got %0d need 0", match_count[31:0]); end
    if (drop_count !== 32'd0) begin failures++; $display("FAIL hdr_drop: got %0d need 0", drop_count); end
  endtask

  task automatic test_multi();
    logic [NP-1:0] need;
    do_reset();
    cfg_patterns = {64'h0, 64'hFFFFFFFFFFFFFFFF, 64'hDEADBEEF00000000, 64'hDEADBEEF12345678};
    cfg_masks = {8'h00, 8'hFF, 8'hF0, 8'hFF};
    cfg_pattern_en = 4'b1110;
    cfg_drop_mode = 1'b1;
    need = 4'b1010;
    send_pkt(8, 64'hDEADBEEF12345678, 7, 4, 1'b0);
    idle();
    repeat (20) @(negedge clk);
    checks += 2;
    if (rx_d.size() != base) begin failures++; $display("FAIL multi_no_output: got %0d words need 0", rx_d.size() - base); end
    if (drop_count !== 32'(S)) begin failures++; $display("FAIL multi_drop: got %0d need %0d", drop_count, S); end
    for (int i = 0; i < NP; i++) begin
      checks++;
      if (match_count[32*i +: 32] !== 32'(S * int'(need[i]))) begin
        failures++;
        $display("FAIL multi_match%0d: got %0d need %0d", i, match_count[32*i +: 32], S * int'(need[i]));
      end
    end
  endtask

  task automatic test_oversize();
    do_reset();
    cfg_pattern_en = '0;
    cfg_drop_mode = 1'b0;
    send_pkt(20, 64'h0, -1, 5, 1'b0);
    send_pkt(5, 64'h0, -1, 6, 1'b1);
    idle();
    repeat (30) @(negedge clk);
    checks += 3;
    if (rx_d.size() != base + 5) begin failures++; $display("FAIL ovf_size: got %0d need 5", rx_d.size() - base); end
    for (int i = 0; i < ex_d.size() && base + i < rx_d.size(); i++) begin
      checks++;
      if (rx_d[base+i] !== ex_d[i] || rx_c[base+i] !== ex_c[i]) begin
        failures++;
        $display("FAIL ovf_word%0d: got %h/%h need %h/%h", i, rx_c[base+i], rx_d[base+i], ex_c[i], ex_d[i]);
      end
    end
    if (oversize_count !== 32'(S)) begin failures++; $display("FAIL ovf_count: got %0d need %0d", oversize_count, S); end
    if (drop_count !== 32'd0) begin failures++; $display("FAIL ovf_drop: got %0d need 0", drop_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cfg_pattern_en = '0;
    out_rdy = 1'b0;
    send_pkt(6, 64'h0, -1, 7, 1'b0);
    send_word(64'hAAAA000000000001, 8'hFF);
    send_word(64'hAAAA000000000002, 8'h00);
    @(negedge clk);
    in_wr = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    out_rdy = 1'b1;
    base = rx_d.size();
    send_pkt(5, 64'h0, -1, 8, 1'b1);
    idle();
    repeat (20) @(negedge clk);
    checks++;
    if (rx_d.size() != base + 5) begin failures++; $display("FAIL rstmid_size: got %0d need 5", rx_d.size() - base); end
    for (int i = 0; i < ex_d.size() && base + i < rx_d.size(); i++) begin
      checks++;
      if (rx_d[base+i] !== ex_d[i]) begin failures++; $display("FAIL rstmid_word%0d: got %h need %h", i, rx_d[base+i], ex_d[i]); end
    end
  endtask

  task automatic test_back_to_back();
    bit done = 1'b0;
    int k = 0;
    logic [63:0] prev_d;
    logic [7:0] prev_c;
    do_reset();
    set_pat0(1'b1);
    fork
      begin
        for (int p = 0; p < 40; p++) begin
          if (p == 20) begin
            idle();
            cfg_clear = 1'b1;
            @(negedge clk);
            cfg_clear = 1'b0;
          end
          send_pkt(6, 64'hFFAABBCCDDEEFF11, (p % 5 == 2) ? 4 : -1, 16 + p, p % 5 != 2);
        end
        idle();
        done = 1'b1;
      end
      begin
        prev_d = out_data;
        prev_c = out_ctrl;
        while (!done) begin
          @(negedge clk);
          out_rdy = 1'($urandom_range(0, 1));
          if (!out_wr) begin
            checks++;
            if (out_data !== prev_d || out_ctrl !== prev_c) begin
              failures++;
              $display("FAIL hold_output: got %h/%h need %h/%h", out_ctrl, out_data, prev_c, prev_d);
            end
          end
          prev_d = out_data;
          prev_c = out_ctrl;
        end
      end
    join
    out_rdy = 1'b1;
    while (rx_d.size() < base + ex_d.size() && k < 2000) begin
      @(negedge clk);
      k++;
    end
    repeat (5) @(negedge clk);
    checks += 3;
    if (rx_d.size() != base + 192) begin failures++; $display("FAIL b2b_size: got %0d need 192", rx_d.size() - base); end
    for (int i = 0; i < ex_d.size() && base + i < rx_d.size(); i++) begin
      checks++;
      if (rx_d[base+i] !== ex_d[i] || rx_c[base+i] !== ex_c[i]) begin
        failures++;
        $display("FAIL b2b_word%0d: got %h/%h need %h/%h", i, rx_c[base+i], rx_d[base+i], ex_c[i], ex_d[i]);
      end
    end
    if (drop_count !== 32'(4 * S)) begin failures++; $display("FAIL b2b_drop_after_clear: got %0d need %0d", drop_count, 4 * S); end
    if (match_count[31:0] !== 32'(4 * S)) begin
      failures++;
      $display("FAIL b2b_match0_after_clear: got %0d need %0d", match_count[31:0], 4 * S);
    end
  endtask

  initial begin
    test_reset();
    test_drop();
    test_forward();
    test_hdr_only();
    test_multi();
    test_oversize();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
